// File: rtl/gbsha_pkg.sv
// Shared types, widths and the accumulator saturation helper for the
// leaky integrator. Widths here describe the default build.
package gbsha_pkg;

  localparam int BW_IN_DEF      = 2;
  localparam int BW_OUT_DEF     = 4;
  localparam int BW_ACC_DEF     = 6;
  localparam int BW_COEF_DEF    = 5;
  localparam int COEF_FRAC_DEF  = 3;
  localparam int COEF_RESET_DEF = 8;

  // Full-precision product, and a sum wide enough that x + (prod >>> frac)
  // can never overflow before saturation.
  localparam int PROD_W = BW_COEF_DEF + BW_ACC_DEF;
  localparam int SUM_W  = PROD_W - COEF_FRAC_DEF + 1;

  // FSM encoding kept as plain constants so older tools see the same codes.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MUL   = 3'd1;
  localparam state_t ST_ACC   = 3'd2;
  localparam state_t ST_LOAD  = 3'd3;
  localparam state_t ST_LDONE = 3'd4;

  // Accumulator limits: largest positive and most negative BW_ACC value.
  localparam logic signed [BW_ACC_DEF-1:0] ACC_MAX = {1'b0, {(BW_ACC_DEF-1){1'b1}}};
  localparam logic signed [BW_ACC_DEF-1:0] ACC_MIN = {1'b1, {(BW_ACC_DEF-1){1'b0}}};

  // Clamp a wide signed sum into the accumulator range instead of wrapping.
  function automatic logic signed [BW_ACC_DEF-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
    if (s > SUM_W'(ACC_MAX))
      return ACC_MAX;
    else if (s < SUM_W'(ACC_MIN))
      return ACC_MIN;
    else
      return s[BW_ACC_DEF-1:0];
  endfunction

endpackage

// File: rtl/gbsha_coef_loader.sv
// Serial coefficient loader: shifts coef_bit in MSB first while the FSM is
// in its load state, commits the word after BW_coef bits, and discards a
// partial word if coef_load drops early.
module gbsha_coef_loader
  import gbsha_pkg::*;
#(
  parameter int BW_coef    = BW_COEF_DEF,
  parameter int COEF_RESET = COEF_RESET_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_active,
  input  logic                      coef_load,
  input  logic                      coef_bit,
  output logic signed [BW_coef-1:0] coef,
  output logic                      commit
);

  localparam int CNT_W = $clog2(BW_coef + 1);

  // Only BW_coef-1 bits need storing: the final bit arrives on the commit
  // cycle and is concatenated straight into the coefficient register.
  logic [BW_coef-2:0]        shadow_reg;
  logic [CNT_W-1:0]          bitcnt_reg;
  logic signed [BW_coef-1:0] coef_reg;
  logic                      shift_en;

  assign shift_en = load_active && coef_load;
  assign commit   = shift_en && (bitcnt_reg == CNT_W'(BW_coef - 1));
  assign coef     = coef_reg;

  // Shift/count while loading; commit on the last bit, clear count on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg <= '0;
      bitcnt_reg <= '0;
      coef_reg   <= BW_coef'(COEF_RESET);
    end else if (shift_en) begin
      shadow_reg <= (BW_coef-1)'({shadow_reg, coef_bit});
      if (commit) begin
        coef_reg   <= {shadow_reg, coef_bit};
        bitcnt_reg <= '0;
      end else begin
        bitcnt_reg <= bitcnt_reg + CNT_W'(1);
      end
    end else if (load_active) begin
      bitcnt_reg <= '0;
    end
  end

endmodule

// File: rtl/gbsha_leaky_integrator.sv
// First-order leaky integrator y = sat(x + (A*y) >>> COEF_FRAC), undoing
// the 2-tap differentiator on the transmit side. One sample takes three
// cycles (accept, multiply, accumulate); A is loaded serially.
module gbsha_leaky_integrator
  import gbsha_pkg::*;
#(
  parameter int BW_in      = BW_IN_DEF,
  parameter int BW_out     = BW_OUT_DEF,
  parameter int BW_acc     = BW_ACC_DEF,
  parameter int BW_coef    = BW_COEF_DEF,
  parameter int COEF_FRAC  = COEF_FRAC_DEF,
  parameter int COEF_RESET = COEF_RESET_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BW_in-1:0]  x_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_load,
  input  logic              coef_bit,
  output logic [BW_out-1:0] y_out,
  output logic              out_valid
);

  localparam int PROD_BITS = BW_coef + BW_acc;
  localparam int SUM_BITS  = PROD_BITS - COEF_FRAC + 1;

  state_t                      state_reg;
  state_t                      state_next;
  logic signed [BW_in-1:0]     x_reg;
  logic signed [PROD_BITS-1:0] prod_reg;
  logic signed [BW_acc-1:0]    y_reg;
  logic [BW_out-1:0]           y_out_reg;
  logic                        out_valid_reg;
  logic signed [BW_coef-1:0]   coef;
  logic                        coef_commit;
  logic signed [SUM_BITS-1:0]  sum;
  logic signed [BW_acc-1:0]    sat;
  logic                        accept;

  // A pending load request blocks sample acceptance in the same cycle.
  assign in_ready  = (state_reg == ST_IDLE) && !coef_load && !reset;
  assign accept    = in_valid && in_ready;
  assign y_out     = y_out_reg;
  assign out_valid = out_valid_reg;

  // Arithmetic shift floors toward -inf; the sum is wide enough not to wrap.
  assign sum = SUM_BITS'(x_reg) + SUM_BITS'(prod_reg >>> COEF_FRAC);
  assign sat = sat_acc(sum);

  gbsha_coef_loader #(
    .BW_coef    (BW_coef),
    .COEF_RESET (COEF_RESET)
  ) u_coef_loader (
    .clk         (clk),
    .reset       (reset),
    .load_active (state_reg == ST_LOAD),
    .coef_load   (coef_load),
    .coef_bit    (coef_bit),
    .coef        (coef),
    .commit      (coef_commit)
  );

  // Next-state logic; loads only start from IDLE so in-flight samples finish.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (coef_load)
          state_next = ST_LOAD;
        else if (accept)
          state_next = ST_MUL;
      end
      ST_MUL:   state_next = ST_ACC;
      ST_ACC:   state_next = ST_IDLE;
      ST_LOAD: begin
        if (!coef_load)
          state_next = ST_IDLE;
        else if (coef_commit)
          state_next = ST_LDONE;
      end
      ST_LDONE: begin
        if (!coef_load)
          state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register plus the sample/product/accumulator datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      prod_reg      <= '0;
      y_reg         <= '0;
      y_out_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_reg == ST_ACC);
      if (state_reg == ST_IDLE && accept)
        x_reg <= x_in;
      if (state_reg == ST_MUL)
        prod_reg <= PROD_BITS'(coef) * PROD_BITS'(y_reg);
      if (state_reg == ST_ACC) begin
        y_reg     <= sat;
        y_out_reg <= sat[BW_acc-1 -: BW_out];
      end
    end
  end

endmodule

// File: tb/tb_gbsha_leaky_integrator.sv
// Scoreboard bench for the leaky integrator: the driver pushes the expected
// output of each accepted sample, a negedge monitor pops and compares.
module tb_gbsha_leaky_integrator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] x_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       coef_load = 1'b0;
  logic       coef_bit = 1'b0;
  logic [3:0] y_out;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int yout;
    int y;
    int due;
  } exp_t;

  exp_t sb[$];
  int   model_y = 0;
  int   model_a = 8;

  gbsha_leaky_integrator dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_load (coef_load),
    .coef_bit  (coef_bit),
    .y_out     (y_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0)))
      q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int v);
    if (v > 31) return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid strobe must match the oldest pending sample.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out y_out=%0d exp=%0d (model y=%0d) cycle=%0d due=%0d",
                 $signed(y_out), e.yout, e.y, cyc, e.due);
        check("y_out", int'($signed(y_out)), e.yout);
        check("latency", cyc, e.due);
      end
    end
  end

  // Offer one sample; the model result is queued at the accepting edge.
  task automatic send(input int x, input bit hold, input bit chk_pat);
    int   waits;
    exp_t e;
    waits = 0;
    in_valid = 1'b1;
    x_in = 2'(x);
    while (!in_ready && waits < 30) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (chk_pat) check("in_ready_gap", waits, 2);
    model_y = clamp(x + fdiv(model_a * model_y, 8));
    e.y = model_y;
    e.yout = fdiv(model_y, 4);
    e.due = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  // Serial load: first high cycle moves IDLE->LOAD, next five carry bits.
  task automatic load(input logic [4:0] bits, input int hold);
    int         guard;
    logic [4:0] sh;
    guard = 0;
    sh = bits;
    in_valid = 1'b0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check("drain_before_load", sb.size(), 0);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      coef_load = 1'b1;
      if (i >= 1 && i <= 5) begin
        coef_bit = sh[4];
        sh = sh << 1;
      end else begin
        coef_bit = 1'($urandom);
      end
      #1 check("in_ready_during_load", int'(in_ready), 0);
      @(negedge clk);
    end
    coef_load = 1'b0;
    coef_bit = 1'b0;
    #1 check("in_ready_at_release", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_after_release", int'(in_ready), 1);
    if (hold >= 6) model_a = int'($signed(bits));
    $display("load bits=%b hold=%0d model_a=%0d", bits, hold, model_a);
  endtask

  // Asynchronous reset, checked immediately rather than at a clock edge.
  task automatic do_reset(input int pre_delay);
    #(pre_delay) reset = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_in_ready", int'(in_ready), 0);
    sb.delete();
    model_y = 0;
    model_a = 8;
    in_valid = 1'b0;
    coef_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Pure integration of +1 with in_valid held: ramp then saturate at 31.
    do_reset(1);
    for (int i = 0; i < 40; i++) send(1, 1'b1, i > 0);
    drain();

    // Negative ramp saturating at -32.
    do_reset(1);
    for (int i = 0; i < 20; i++) send(-2, 1'b1, i > 0);
    drain();

    // A = 0.5 decay from 31.
    do_reset(1);
    for (int i = 0; i < 35; i++) send(1, 1'b1, 1'b0);
    load(5'b00100, 6);
    for (int i = 0; i < 6; i++) send(0, 1'b0, 1'b0);
    drain();

    // A = -1.0 from 31: sign alternates.
    do_reset(1);
    for (int i = 0; i < 35; i++) send(1, 1'b1, 1'b0);
    load(5'b11000, 6);
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0);
    drain();

    // Aborted load keeps A = 1.0; held load commits after five bits.
    do_reset(1);
    load(5'b00100, 3);
    for (int i = 0; i < 4; i++) send(1, 1'b0, 1'b0);
    load(5'b00100, 8);
    for (int i = 0; i < 3; i++) send(0, 1'b0, 1'b0);
    drain();

    // Reset during MUL: pending result is dropped and A returns to 1.0.
    do_reset(1);
    for (int i = 0; i < 6; i++) send(1, 1'b0, 1'b0);
    load(5'b00100, 6);
    send(1, 1'b0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 4; i++) send(1, 1'b0, 1'b0);
    drain();

    // Randomized samples, gaps and loads (including aborts).
    do_reset(1);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        load(5'($urandom), $urandom_range(1, 9));
      end else begin
        send(int'($urandom_range(0, 3)) - 2, 1'($urandom), 1'b0);
        if (!in_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
